// File: rtl/count_stream_decoder.sv
// rtl/count_stream_decoder.sv - infers binary/Gray mode and direction from a counter stream, decodes it and flags bad steps
// Optional saturating error counter: define ERR_CNT_EN.
module count_stream_decoder #(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_vld,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    bin_out,
  output logic                mode_out,
  output logic                dir_out,
  output logic                locked,
  output logic                hold,
  output logic                mode_chg,
  output logic                step_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [2:0] LOCK_N  = 3'(LOCK_LEN);

  // Hypothesis mask bit order: {GD, GU, BD, BU}
  logic [1:0]       state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [2:0]       run_q, run_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             mode_q, mode_d, dir_q, dir_d;
  logic             hold_q, hold_d, chg_q, chg_d, err_q, err_d;

  logic [WIDTH-1:0] gp, gn;
  logic [3:0]       step;
  logic             same, one_hot;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    gp      = g2b(prev_q);
    gn      = g2b(din);
    same    = (din == prev_q);
    step[0] = (din == prev_q + WIDTH'(1));
    step[1] = (din == prev_q - WIDTH'(1));
    step[2] = (gn == gp + WIDTH'(1));
    step[3] = (gn == gp - WIDTH'(1));
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    run_d   = run_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    hold_d  = 1'b0;
    chg_d   = 1'b0;
    err_d   = 1'b0;
    one_hot = 1'b0;
    if (din_vld) begin
      prev_d = din;
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          mask_d  = 4'b1111;
          run_d   = 3'd0;
        end
        ACQUIRE: begin
          if (same) begin
            hold_d = 1'b1;
          end else if (step == 4'b0000) begin
            err_d  = 1'b1;
            mask_d = 4'b1111;
            run_d  = 3'd0;
          end else begin
            if ((mask_q & step) != 4'b0000) begin
              mask_d = mask_q & step;
              run_d  = (run_q >= LOCK_N) ? LOCK_N : run_q + 3'd1;
            end else begin
              mask_d = step;
              run_d  = 3'd1;
            end
            one_hot = ((mask_d & (mask_d - 4'd1)) == 4'b0000);
            if (one_hot && run_d >= LOCK_N) begin
              state_d = LOCKED;
              mode_d  = mask_d[2] | mask_d[3];
              dir_d   = mask_d[0] | mask_d[2];
            end
          end
        end
        LOCKED: begin
          if (same) begin
            hold_d = 1'b1;
          end else if (step == 4'b0000) begin
            err_d   = 1'b1;
            state_d = ACQUIRE;
            mask_d  = 4'b1111;
            run_d   = 3'd0;
          end else if ((mask_q & step) == 4'b0000) begin
            chg_d   = 1'b1;
            state_d = ACQUIRE;
            mask_d  = step;
            run_d   = 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      // Decode with the mode that will be visible alongside this sample
      bin_d = mode_d ? gn : din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 4'b0000;
      run_q   <= 3'd0;
      prev_q  <= '0;
      bin_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      hold_q  <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [ERRCNT_W-1:0] errcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) errcnt_q <= '0;
    else if (err_d && errcnt_q != {ERRCNT_W{1'b1}}) errcnt_q <= errcnt_q + ERRCNT_W'(1);
  end
  assign err_cnt = errcnt_q;
`else
  assign err_cnt = '0;
`endif

  assign bin_out  = bin_q;
  assign mode_out = mode_q;
  assign dir_out  = dir_q;
  assign locked   = (state_q == LOCKED);
  assign hold     = hold_q;
  assign mode_chg = chg_q;
  assign step_err = err_q;

endmodule

// File: tb/tb_count_stream_decoder.sv
// tb/tb_count_stream_decoder.sv - table-driven scoreboard bench for count_stream_decoder
module tb_count_stream_decoder;

  typedef struct packed {
    logic       vld;
    logic [2:0] din;
    logic [2:0] bin;
    logic       mode, dir, lck, hold, chg, err;
    logic [7:0] ecnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_vld = 1'b0;
  logic [2:0] din = 3'd0;
  logic [2:0] bin_out;
  logic       mode_out, dir_out, locked, hold, mode_chg, step_err;
  logic [7:0] err_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];

  count_stream_decoder #(.WIDTH(3), .LOCK_LEN(2), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
    .bin_out(bin_out), .mode_out(mode_out), .dir_out(dir_out), .locked(locked),
    .hold(hold), .mode_chg(mode_chg), .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] d, input logic [2:0] b,
                              input logic m, input logic dr, input logic l, input logic h,
                              input logic c, input logic e, input logic [7:0] ec);
    vec_t r;
    r.vld = v; r.din = d; r.bin = b; r.mode = m; r.dir = dr; r.lck = l;
    r.hold = h; r.chg = c; r.err = e; r.ecnt = ec;
    return r;
  endfunction

  function automatic logic [17:0] pack_exp(input vec_t v);
    logic [7:0] ec;
`ifdef ERR_CNT_EN
    ec = v.ecnt;
`else
    ec = 8'd0;
`endif
    return {v.bin, v.mode, v.dir, v.lck, v.hold, v.chg, v.err, ec};
  endfunction

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] got;
    got = {bin_out, mode_out, dir_out, locked, hold, mode_chg, step_err, err_cnt};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got bin=%0d mode=%0d dir=%0d lck=%0d hold=%0d chg=%0d err=%0d ecnt=%0d required bin=%0d mode=%0d dir=%0d lck=%0d hold=%0d chg=%0d err=%0d ecnt=%0d",
               name, got[17:15], got[14], got[13], got[12], got[11], got[10], got[9], got[7:0],
               exp[17:15], exp[14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[7:0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    din_vld = v.vld;
    din     = v.din;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, pack_exp(e));
    end
  endtask

  vec_t t1[21];
  vec_t t2[9];

  initial begin
    //        vld din  bin m  d  l  h  c  e  ecnt
    t1[0]  = mk(1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    t1[1]  = mk(1, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 8'd0);
    t1[2]  = mk(1, 3'd2, 3'd2, 0, 1, 1, 0, 0, 0, 8'd0);
    t1[3]  = mk(0, 3'd5, 3'd2, 0, 1, 1, 0, 0, 0, 8'd0);
    t1[4]  = mk(1, 3'd3, 3'd3, 0, 1, 1, 0, 0, 0, 8'd0);
    t1[5]  = mk(1, 3'd3, 3'd3, 0, 1, 1, 1, 0, 0, 8'd0);
    t1[6]  = mk(1, 3'd3, 3'd3, 0, 1, 1, 1, 0, 0, 8'd0);
    t1[7]  = mk(1, 3'd3, 3'd3, 0, 1, 1, 1, 0, 0, 8'd0);
    t1[8]  = mk(1, 3'd4, 3'd4, 0, 1, 1, 0, 0, 0, 8'd0);
    t1[9]  = mk(1, 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 8'd1);
    t1[10] = mk(1, 3'd7, 3'd7, 0, 1, 0, 1, 0, 0, 8'd1);
    t1[11] = mk(1, 3'd5, 3'd5, 0, 1, 0, 0, 0, 0, 8'd1);
    t1[12] = mk(1, 3'd4, 3'd7, 1, 1, 1, 0, 0, 0, 8'd1);
    t1[13] = mk(1, 3'd0, 3'd0, 1, 1, 1, 0, 0, 0, 8'd1);
    t1[14] = mk(1, 3'd4, 3'd7, 1, 1, 0, 0, 1, 0, 8'd1);
    t1[15] = mk(1, 3'd5, 3'd6, 1, 0, 1, 0, 0, 0, 8'd1);
    t1[16] = mk(1, 3'd7, 3'd5, 1, 0, 1, 0, 0, 0, 8'd1);
    t1[17] = mk(1, 3'd2, 3'd3, 1, 0, 0, 0, 0, 1, 8'd2);
    t1[18] = mk(0, 3'd0, 3'd3, 1, 0, 0, 0, 0, 0, 8'd2);
    t1[19] = mk(1, 3'd3, 3'd2, 1, 0, 0, 0, 0, 0, 8'd2);
    t1[20] = mk(1, 3'd4, 3'd4, 0, 1, 1, 0, 0, 0, 8'd2);

    t2[0] = mk(1, 3'd4, 3'd4, 0, 0, 0, 0, 0, 0, 8'd0);
    t2[1] = mk(1, 3'd5, 3'd5, 0, 0, 0, 0, 0, 0, 8'd0);
    t2[2] = mk(1, 3'd6, 3'd6, 0, 1, 1, 0, 0, 0, 8'd0);
    t2[3] = mk(1, 3'd7, 3'd7, 0, 1, 1, 0, 0, 0, 8'd0);
    t2[4] = mk(1, 3'd0, 3'd0, 0, 1, 1, 0, 0, 0, 8'd0);
    t2[5] = mk(1, 3'd1, 3'd1, 0, 1, 1, 0, 0, 0, 8'd0);
    t2[6] = mk(1, 3'd2, 3'd2, 0, 1, 1, 0, 0, 0, 8'd0);
    t2[7] = mk(1, 3'd5, 3'd5, 0, 1, 0, 0, 0, 1, 8'd1);
    t2[8] = mk(0, 3'd0, 3'd5, 0, 1, 0, 0, 0, 0, 8'd1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 18'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) apply(t1[i], $sformatf("main_vec%0d", i));

    // Asynchronous reset landing between edges while locked
    @(negedge clk);
    din_vld = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", 18'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply(t2[i], $sformatf("relock_vec%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
